// File: rtl/clk_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clk_div_pkg : shared types and helpers for the clk_div_bank divider bank   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package clk_div_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } cfg_state_t;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    // Wide enough for LOCK_CYCLES up to 255.
    localparam int c_lock_cnt_w = 8;
    localparam int c_norm_w     = 32;

    function automatic logic [c_norm_w-1:0] div_norm(input logic [c_norm_w-1:0] d);
        return (d == '0) ? c_norm_w'(1) : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clk_div_ch : one divider channel (counter, active ratio, lock tracking)    |
// | Optional sync input when CLK_DIV_BANK_SYNC_EN is defined. Rev 1.0          |
// +----------------------------------------------------------------------------+
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEF_DIV     = 8,
    parameter int LOCK_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef CLK_DIV_BANK_SYNC_EN
    input  logic             sync,
`endif
    input  logic             apply,
    input  logic [DIV_W-1:0] new_div,
    output logic             tick,
    output logic             level,
    output logic             lock,
    output logic             wrap
);

    logic [DIV_W-1:0]        r_cnt;
    logic [DIV_W-1:0]        r_cur_div;
    lock_state_t             r_lock_state;
    lock_state_t             w_lock_state_nxt;
    logic [c_lock_cnt_w-1:0] r_wrap_cnt;
    logic [c_lock_cnt_w-1:0] w_wrap_cnt_nxt;
    logic [DIV_W:0]          w_half;
    logic                    w_wrap;

    assign w_wrap = en & (r_cnt == r_cur_div - DIV_W'(1));
    // ceil(cur_div/2), one bit wider so the +1 cannot overflow
    assign w_half = ({1'b0, r_cur_div} + (DIV_W+1)'(1)) >> 1;

    assign tick  = w_wrap;
    assign wrap  = w_wrap;
    assign level = en & ({1'b0, r_cnt} < w_half);
    assign lock  = (r_lock_state == LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_cur_div <= DIV_W'(DEF_DIV);
        end else if (apply) begin
            r_cnt     <= '0;
            r_cur_div <= new_div;
        end else if (!en || w_wrap) begin
            r_cnt <= '0;
`ifdef CLK_DIV_BANK_SYNC_EN
        end else if (sync) begin
            r_cnt <= '0;
`endif
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_state <= OFF;
            r_wrap_cnt   <= '0;
        end else begin
            r_lock_state <= w_lock_state_nxt;
            r_wrap_cnt   <= w_wrap_cnt_nxt;
        end
    end

    always_comb begin
        w_lock_state_nxt = r_lock_state;
        w_wrap_cnt_nxt   = r_wrap_cnt;
        if (!en) begin
            w_lock_state_nxt = OFF;
            w_wrap_cnt_nxt   = '0;
        end else if (apply || (r_lock_state == OFF)) begin
            w_lock_state_nxt = SETTLE;
            w_wrap_cnt_nxt   = '0;
        end else if ((r_lock_state == SETTLE) && w_wrap) begin
            if (r_wrap_cnt == c_lock_cnt_w'(LOCK_CYCLES - 1)) begin
                w_lock_state_nxt = LOCKED;
            end else begin
                w_wrap_cnt_nxt = r_wrap_cnt + c_lock_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clk_div_bank : NUM_CH reconfigurable clock-enable dividers, one cfg port   |
// | Optional sync input when CLK_DIV_BANK_SYNC_EN is defined. Rev 1.0          |
// +----------------------------------------------------------------------------+
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int DEF_DIV     = 8,
    parameter int LOCK_CYCLES = 4,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef CLK_DIV_BANK_SYNC_EN
    input  logic              sync,
`endif
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] lock
);

    cfg_state_t        r_cfg_state;
    cfg_state_t        w_cfg_state_nxt;
    logic [CH_W-1:0]   r_pend_ch;
    logic [DIV_W-1:0]  r_pend_div;
    logic              r_cfg_err;
    logic              w_accept;
    logic              w_ch_ok;
    logic [NUM_CH-1:0] w_wrap;
    logic [NUM_CH-1:0] w_apply;

    assign cfg_ready = (r_cfg_state == IDLE);
    assign cfg_err   = r_cfg_err;
    assign w_accept  = cfg_valid & cfg_ready;
    assign w_ch_ok   = (32'(cfg_ch) < 32'(NUM_CH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_state <= IDLE;
        end else begin
            r_cfg_state <= w_cfg_state_nxt;
        end
    end

    always_comb begin
        w_cfg_state_nxt = r_cfg_state;
        case (r_cfg_state)
            IDLE:    if (w_accept && w_ch_ok) w_cfg_state_nxt = PENDING;
            PENDING: if (|w_apply)            w_cfg_state_nxt = IDLE;
            default:                          w_cfg_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_ch  <= '0;
            r_pend_div <= DIV_W'(1);
            r_cfg_err  <= 1'b0;
        end else begin
            r_cfg_err <= w_accept & ~w_ch_ok;
            if (w_accept && w_ch_ok) begin
                r_pend_ch  <= cfg_ch;
                r_pend_div <= DIV_W'(div_norm(c_norm_w'(cfg_div)));
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        // A disabled target has no wrap to wait for, so it takes the ratio at once.
        assign w_apply[gi] = (r_cfg_state == PENDING) && (r_pend_ch == CH_W'(gi))
                             && (!ch_en[gi] || w_wrap[gi]);

        clk_div_ch #(
            .DIV_W       (DIV_W),
            .DEF_DIV     (DEF_DIV),
            .LOCK_CYCLES (LOCK_CYCLES)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (ch_en[gi]),
`ifdef CLK_DIV_BANK_SYNC_EN
            .sync    (sync),
`endif
            .apply   (w_apply[gi]),
            .new_div (r_pend_div),
            .tick    (tick[gi]),
            .level   (level[gi]),
            .lock    (lock[gi]),
            .wrap    (w_wrap[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_clk_div_bank : timestamp-based reference model with per-cycle checking  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_clk_div_bank;

    localparam int NUM_CH      = 3;
    localparam int DIV_W       = 8;
    localparam int DEF_DIV     = 8;
    localparam int LOCK_CYCLES = 4;
    localparam int CH_W        = 2;
    localparam int N_CYC       = 3000;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_err;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] lock;
    logic              sync_in;
`ifdef CLK_DIV_BANK_SYNC_EN
    logic              sync;
`endif

    clk_div_bank #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEF_DIV     (DEF_DIV),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef CLK_DIV_BANK_SYNC_EN
        .sync      (sync),
`endif
        .ch_en     (ch_en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .level     (level),
        .lock      (lock)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: each channel's period started at cycle m_t0; lock = wraps seen since settling.
    int m_div   [NUM_CH];
    int m_t0    [NUM_CH];
    bit m_on    [NUM_CH];
    int m_wraps [NUM_CH];
    bit m_pv;
    int m_pch;
    int m_pdiv;
    bit m_err;
    logic [NUM_CH-1:0] e_tick, e_level, e_lock;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int t0);
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i]   = DEF_DIV;
            m_t0[i]    = t0;
            m_on[i]    = 1'b0;
            m_wraps[i] = 0;
        end
        m_pv  = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic req(input int ch, input int div);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = DIV_W'(div);
    endtask

    task automatic drive(input int c);
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        sync_in   = 1'b0;
        if (c < 100) begin
            ch_en = (c >= 82 && c < 86) ? 3'b110 : 3'b111;
            case (c)
                40: req(0, 5);
                60: req(1, 0);
                70: req(3, 9);
                80: req(0, 7);
                93: req(0, 4);
                95: begin rst = 1'b1; model_reset(c); end
                97: rst = 1'b0;
                default: ;
            endcase
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if ($urandom_range(39) == 0) ch_en[i] = ~ch_en[i];
            if ($urandom_range(3) == 0)
                req(int'($urandom_range(3)),
                    ($urandom_range(7) == 0) ? int'($urandom_range(255)) : int'($urandom_range(12)));
            sync_in = ($urandom_range(29) == 0);
        end
`ifdef CLK_DIV_BANK_SYNC_EN
        sync = sync_in;
`else
        sync_in = 1'b0;
`endif
    endtask

    task automatic predict();
        int ph;
        for (int i = 0; i < NUM_CH; i++) begin
            ph         = (cur_c - m_t0[i]) % m_div[i];
            e_tick[i]  = ch_en[i] && (ph == m_div[i] - 1);
            e_level[i] = ch_en[i] && (ph < (m_div[i] + 1) / 2);
            e_lock[i]  = m_on[i] && (m_wraps[i] >= LOCK_CYCLES);
        end
    endtask

    task automatic model_step(input int c);
        bit ap;
        bit any_ap;
        any_ap = 1'b0;
        if (rst) begin
            model_reset(c + 1);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                ap = m_pv && (m_pch == i) && (!ch_en[i] || e_tick[i]);
                any_ap |= ap;
                if (ap) m_div[i] = m_pdiv;
                if (ap || !ch_en[i] || sync_in) m_t0[i] = c + 1;
                if (!ch_en[i]) m_on[i] = 1'b0;
                else if (!m_on[i] || ap) begin m_on[i] = 1'b1; m_wraps[i] = 0; end
                else if (e_tick[i]) m_wraps[i]++;
            end
            m_err = 1'b0;
            if (m_pv) begin
                if (any_ap) m_pv = 1'b0;
            end else if (cfg_valid) begin
                if (int'(cfg_ch) < NUM_CH) begin
                    m_pv   = 1'b1;
                    m_pch  = int'(cfg_ch);
                    m_pdiv = (cfg_div == '0) ? 1 : int'(cfg_div);
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    int cur_c;

    initial begin
        rst       = 1'b1;
        ch_en     = '0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        sync_in   = 1'b0;
`ifdef CLK_DIV_BANK_SYNC_EN
        sync      = 1'b0;
`endif
        model_reset(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tick",  -1, 32'(tick),      32'd0);
        chk("rst_level", -1, 32'(level),     32'd0);
        chk("rst_lock",  -1, 32'(lock),      32'd0);
        chk("rst_ready", -1, 32'(cfg_ready), 32'd1);
        chk("rst_err",   -1, 32'(cfg_err),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int c = 0; c < N_CYC; c++) begin
            cur_c = c;
            drive(c);
            @(negedge clk);
            predict();
            chk("tick",  c, 32'(tick),      32'(e_tick));
            chk("level", c, 32'(level),     32'(e_level));
            chk("lock",  c, 32'(lock),      32'(e_lock));
            chk("ready", c, 32'(cfg_ready), 32'(!m_pv));
            chk("err",   c, 32'(cfg_err),   32'(m_err));
            // Hand-derived anchors for the directed opening.
            case (c)
                7:  chk("lit_tick0_first",   c, 32'(tick[0]),   32'd1);
                31: chk("lit_lock0_early",   c, 32'(lock[0]),   32'd0);
                32: chk("lit_lock0_set",     c, 32'(lock[0]),   32'd1);
                47: chk("lit_ready_apply",   c, 32'(cfg_ready), 32'd0);
                48: chk("lit_ready_after",   c, 32'(cfg_ready), 32'd1);
                52: chk("lit_tick0_div5",    c, 32'(tick[0]),   32'd1);
                55: chk("lit_level0_high",   c, 32'(level[0]),  32'd1);
                56: chk("lit_level0_low",    c, 32'(level[0]),  32'd0);
                70: chk("lit_tick1_div1",    c, 32'(tick[1]),   32'd1);
                71: chk("lit_err_pulse",     c, 32'(cfg_err),   32'd1);
                72: chk("lit_err_single",    c, 32'(cfg_err),   32'd0);
                83: chk("lit_lock0_off",     c, 32'(lock[0]),   32'd0);
                92: chk("lit_tick0_div7",    c, 32'(tick[0]),   32'd1);
                96: chk("lit_ready_rst",     c, 32'(cfg_ready), 32'd1);
                default: ;
            endcase
            @(posedge clk);
            model_step(c);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
Parametrised, runtime-reconfigurable clock-enable generator for the LCD/CPU fabric. It derives NUM_CH independent tick/square-wave streams from the single PLL output clock, each with its own divide ratio. Ratios can be reprogrammed through a valid/ready port and take effect glitch-free at the channel's next period boundary. Each channel has a per-channel lock indication.

Parameters:
NUM_CH, 2, number of divider channels (1..8)
DIV_W, 8, divide-ratio width; ratio range 1..2^DIV_W-1
DEF_DIV, 8, divide ratio of every channel after reset
LOCK_CYCLES, 4, full periods at a new ratio before lock asserts (1..255)

Ports:
clk  in  1  single system clock (PLL output)
rst  in  1  asynchronous, active-high reset
ch_en  in  NUM_CH  per-channel run enable
cfg_valid  in  1  reconfiguration request
cfg_ready  out  1  bank can accept a request
cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
cfg_div  in  DIV_W  new divide ratio; 0 is treated as 1
cfg_err  out  1  one-cycle pulse: accepted request with cfg_ch >= NUM_CH
tick  out  NUM_CH  one-cycle enable per period
level  out  NUM_CH  square wave
lock  out  NUM_CH  channel running at a settled ratio

Behaviour:
- Reset (async assert, release on clk): cur_div=DEF_DIV, cnt=0, pending empty, lock state OFF. Output reset values: tick=0, level=0, lock=0, cfg_ready=1, cfg_err=0.
- Per-channel counter:
  - cnt runs 0..cur_div-1 while ch_en=1, then wraps to 0. With ch_en=0, cnt is held at 0.
  - tick = ch_en & (cnt==cur_div-1).
  - level = ch_en & (cnt < ceil(cur_div/2)).
  - Both outputs are decoded from registers only; no extra latency.
  - cur_div=1: tick is constant 1 and level is constant 1 while enabled.
- Config handshake (global FSM IDLE/PENDING):
  - A request is accepted when cfg_valid & cfg_ready.
  - IDLE: on accept with a valid channel, latch ch/div (0 maps to 1), go to PENDING, drop cfg_ready the next cycle.
  - IDLE: on accept with cfg_ch >= NUM_CH, pulse cfg_err the next cycle, drop the request, stay IDLE.
  - PENDING: the ratio is applied at the target channel's wrap cycle (tick=1): cur_div <= pend_div, cnt <= 0. Return to IDLE; cfg_ready=1 on the following cycle.
  - PENDING with the target channel disabled: apply on the next clk edge.
  - cfg_valid during PENDING, including the apply cycle, is not accepted.
  - Requests for a ratio equal to cur_div follow the same path and still re-lock.
- Lock FSM per channel (OFF, SETTLE, LOCKED):
  - OFF -> SETTLE when ch_en=1.
  - SETTLE counts wraps; after LOCK_CYCLES wraps -> LOCKED, lock=1.
  - Any state -> OFF when ch_en=0.
  - LOCKED/SETTLE -> SETTLE (count cleared) when the channel's pending ratio is applied.
  - lock drops in the cycle after apply.
- Simultaneous events: ch_en falling in the same cycle as apply still applies the ratio; the channel goes OFF.
- rst asserted mid-PENDING discards the pending request.

Optional Feature:
CLK_DIV_BANK_SYNC_EN.
- Defined: adds input sync (1 bit). sync=1 forces cnt=0 on every enabled channel at the next edge, phase-aligning all channels.
  - lock state is unaffected; the forced restart does not count as a wrap.
  - If sync coincides with a pending apply, the apply wins for the target channel (cnt=0, new ratio).
- Undefined: no sync port; counters free-run.

Decomposition:
- Package clk_div_pkg holds:
  - cfg FSM enum (IDLE, PENDING);
  - lock FSM enum (OFF, SETTLE, LOCKED);
  - function div_norm (0→1);
  - localparam for lock-counter width.
- Sub-module clk_div_ch (one per channel, generate loop) holds:
  - cnt, cur_div and lock FSM;
  - inputs apply/new_div/en (and sync);
  - outputs tick/level/lock/wrap.
- Top level holds the cfg FSM and the pending register.

Test Plan:
- Reset release, ch_en=2'b11, defaults: tick every 8 cycles, level high 4/low 4. lock rises after 4th tick (32 cycles after enable + 1).
- cfg ch0 div=5 accepted mid-period: old period completes (8 cycles), then tick every 5. level high 3/low 2. cfg_ready low until cycle after apply. lock0 drops and re-asserts after 4 periods of 5. ch1 undisturbed.
- cfg_div=0 to ch1: applied as div 1, tick1 and level1 constant 1 after apply.
- cfg_ch=3 with NUM_CH=2: cfg_err single pulse, cfg_ready stays 1, no channel changes.
- ch0 disabled while PENDING on ch0: ratio applied next edge. tick0/level0/lock0=0. Re-enable gives the new period from cnt=0.
- SYNC_EN build: div0=3, div1=6, pulse sync: both cnt=0 next cycle, ticks coincide every 6 cycles, lock unchanged.
